// File: rtl/sys_ctrl_pkg.sv
// Shared system-controller definitions: widths, state encodings, command opcodes and
// small helpers used by the Tx-side response path (and opcodes by the Rx-side controller).
package sys_ctrl_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ALU_W      = 16;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned NB         = ALU_W / DATA_W;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned IDX_W      = $clog2(NB) + 1;

  typedef enum logic [7:0] {
    CMD_RF_WR   = 8'hAA,
    CMD_RF_RD   = 8'hBB,
    CMD_ALU_OP  = 8'hCC,
    CMD_ALU_NOP = 8'hDD
  } cmd_t;

  typedef enum logic {
    P_IDLE,
    P_ALU
  } pk_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_START,
    S_DONE
  } tx_state_t;

  // One-byte holding slot for read data that arrives while an ALU frame is being packed
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } byte_slot_t;

  function automatic logic [DATA_W-1:0] alu_byte(input logic [ALU_W-1:0] v,
                                                 input logic [IDX_W-1:0] i);
    return DATA_W'(v >> (32'(i) * DATA_W));
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_if.sv
// Response-path bus: ALU/RegFile producers in, UART Tx handshake and status out.
interface sys_ctrl_tx_if;
  import sys_ctrl_pkg::*;

  logic [ALU_W-1:0]  ALU_OUT;
  logic              OUT_Valid;
  logic [DATA_W-1:0] RdData;
  logic              RdData_Valid;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              TX_D_VLD;
  logic              TX_Busy;
  logic              Busy;
  logic              Overflow;

  modport master (
    output ALU_OUT, OUT_Valid, RdData, RdData_Valid, TX_Busy,
    input  TX_P_DATA, TX_D_VLD, Busy, Overflow
  );

  modport slave (
    input  ALU_OUT, OUT_Valid, RdData, RdData_Valid, TX_Busy,
    output TX_P_DATA, TX_D_VLD, Busy, Overflow
  );
endinterface

// File: rtl/sys_ctrl_tx_fifo.sv
// Synchronous byte FIFO; push and pop may coincide at any fill level, including full.
module sys_ctrl_tx_fifo
  import sys_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout_c,
  output logic [CNT_W-1:0]  count,
  output logic              empty_c
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
  assign dout_c  = mem[rd_ptr];
  assign empty_c = (count == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are only visible through count/pointers
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sys_ctrl_tx.sv
// System-controller response path: packs RegFile/ALU results into bytes, queues them
// and feeds UART Tx one byte per TX_D_VLD/TX_Busy handshake.
module sys_ctrl_tx
  import sys_ctrl_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  sys_ctrl_tx_if.slave bus
);

  pk_state_t         pk_state, pk_next;
  tx_state_t         tx_state, tx_next;
  logic [ALU_W-1:0]  alu_lat;
  logic [IDX_W-1:0]  idx;
  byte_slot_t        pend;
  logic              overflow;
  logic              busy;
  logic              tx_vld;
  logic [DATA_W-1:0] tx_data;

  logic              push_c;
  logic [DATA_W-1:0] push_data_c;
  logic              pend_load_c;
  logic              pend_clr_c;
  logic              ovf_set_c;
  logic              pop_c;
  logic [DATA_W-1:0] fifo_dout_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty_c;
  logic [CNT_W-1:0]  free_c;
  logic              alu_fits_c;
  logic              byte_fits_c;
  logic              alu_take_c;

  sys_ctrl_tx_fifo u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push_c),
    .din     (push_data_c),
    .pop     (pop_c),
    .dout_c  (fifo_dout_c),
    .count   (fifo_count),
    .empty_c (fifo_empty_c)
  );

  // Admission looks at this cycle's free space only; a same-cycle pop is not credited
  assign free_c      = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign alu_fits_c  = (free_c >= CNT_W'(NB));
  assign byte_fits_c = (free_c != '0);
  assign alu_take_c  = (pk_state == P_IDLE) && bus.OUT_Valid && alu_fits_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) pk_state <= P_IDLE;
    else      pk_state <= pk_next;
  end

  always_comb begin
    pk_next = pk_state;
    case (pk_state)
      P_IDLE:  if (alu_take_c) pk_next = P_ALU;
      P_ALU:   if (idx == IDX_W'(NB - 1)) pk_next = P_IDLE;
      default: pk_next = P_IDLE;
    endcase
  end

  // Packer actions: ALU frame wins the push; read data waits in the pending slot
  always_comb begin
    push_c      = 1'b0;
    push_data_c = '0;
    pend_load_c = 1'b0;
    pend_clr_c  = 1'b0;
    ovf_set_c   = 1'b0;
    if (pk_state == P_ALU) begin
      push_c      = 1'b1;
      push_data_c = alu_byte(alu_lat, idx);
      if (bus.OUT_Valid) ovf_set_c = 1'b1;
      if (bus.RdData_Valid) begin
        if (pend.vld) ovf_set_c   = 1'b1;
        else          pend_load_c = 1'b1;
      end
    end else if (alu_take_c) begin
      push_c      = 1'b1;
      push_data_c = bus.ALU_OUT[DATA_W-1:0];
      if (bus.RdData_Valid) begin
        if (pend.vld) ovf_set_c   = 1'b1;
        else          pend_load_c = 1'b1;
      end
    end else begin
      if (bus.OUT_Valid) ovf_set_c = 1'b1;
      if (pend.vld) begin
        pend_clr_c = 1'b1;
        if (byte_fits_c) begin
          push_c      = 1'b1;
          push_data_c = pend.data;
        end else begin
          ovf_set_c = 1'b1;
        end
        if (bus.RdData_Valid) pend_load_c = 1'b1;
      end else if (bus.RdData_Valid) begin
        if (byte_fits_c) begin
          push_c      = 1'b1;
          push_data_c = bus.RdData;
        end else begin
          ovf_set_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_lat  <= '0;
      idx      <= '0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      if (alu_take_c) begin
        alu_lat <= bus.ALU_OUT;
        idx     <= IDX_W'(1);
      end else if (pk_state == P_ALU) begin
        idx <= idx + IDX_W'(1);
      end
      if (pend_load_c)     pend <= '{vld: 1'b1, data: bus.RdData};
      else if (pend_clr_c) pend.vld <= 1'b0;
      if (ovf_set_c) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tx_state <= S_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (!fifo_empty_c) tx_next = S_REQ;
      S_REQ:   if (!bus.TX_Busy)  tx_next = S_START;
      S_START: if (bus.TX_Busy)   tx_next = S_DONE;
      S_DONE:  if (!bus.TX_Busy)  tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop_c = (tx_state == S_IDLE) && !fifo_empty_c;
  end

  // TX_D_VLD mirrors S_REQ; push_c keeps Busy continuous across the first push
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_data <= '0;
      tx_vld  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (pop_c) tx_data <= fifo_dout_c;
      tx_vld <= (tx_next == S_REQ);
      busy   <= !fifo_empty_c || (pk_state != P_IDLE) || pend.vld ||
                (tx_state != S_IDLE) || push_c;
    end
  end

  assign bus.TX_P_DATA = tx_data;
  assign bus.TX_D_VLD  = tx_vld;
  assign bus.Busy      = busy;
  assign bus.Overflow  = overflow;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Directed bench for sys_ctrl_tx with a simple UART Tx busy model.
module tb_sys_ctrl_tx;
  import sys_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sys_ctrl_tx_if bus();

  sys_ctrl_tx dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic [7:0] got[$];
  int early = 0;

  assign bus.TX_Busy = model_busy | force_busy;

  // UART Tx model: accept on an edge with TX_D_VLD & !TX_Busy, then busy for 10 cycles
  initial begin
    forever begin
      @(negedge CLK);
      if (RST && bus.TX_D_VLD && !bus.TX_Busy) begin
        got.push_back(bus.TX_P_DATA);
        @(posedge CLK);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge CLK);
        #1 model_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) if (bus.TX_D_VLD && model_busy) early++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_alu(input logic [15:0] v);
    bus.ALU_OUT   = v;
    bus.OUT_Valid = 1'b1;
    cyc(1);
    bus.OUT_Valid = 1'b0;
  endtask

  task automatic drive_rd(input logic [7:0] v);
    bus.RdData       = v;
    bus.RdData_Valid = 1'b1;
    cyc(1);
    bus.RdData_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((bus.Busy || bus.TX_Busy || bus.TX_D_VLD) && n < 500) begin
      cyc(1);
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s drain_timeout busy=%b tx_busy=%b vld=%b", name, bus.Busy, bus.TX_Busy,
               bus.TX_D_VLD);
    end
  endtask

  task automatic test_reset;
    cyc(2);
    total++;
    if (bus.TX_D_VLD !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", bus.TX_D_VLD); end
    total++;
    if (bus.TX_P_DATA !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", bus.TX_P_DATA); end
    total++;
    if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.Busy); end
    total++;
    if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.Overflow); end
    RST = 1'b1;
    cyc(3);
    total++;
    if (bus.Busy !== 1'b0 || bus.TX_D_VLD !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle busy=%b vld=%b exp=0/0", bus.Busy, bus.TX_D_VLD);
    end
  endtask

  task automatic test_read;
    got.delete();
    drive_rd(8'h5A);
    total++;
    if (bus.TX_D_VLD !== 1'b0) begin bad++; $display("FAIL rd_cyc1_vld got=%b exp=0", bus.TX_D_VLD); end
    cyc(1);
    total++;
    if (bus.TX_D_VLD !== 1'b1) begin bad++; $display("FAIL rd_cyc2_vld got=%b exp=1", bus.TX_D_VLD); end
    total++;
    if (bus.TX_P_DATA !== 8'h5A) begin bad++; $display("FAIL rd_cyc2_data got=%h exp=5a", bus.TX_P_DATA); end
    wait_idle("rd");
    total++;
    if (got.size() != 1 || got[0] !== 8'h5A) begin
      bad++; $display("FAIL rd_bytes count=%0d first=%h exp=1/5a", got.size(), got.size() ? got[0] : 8'h00);
    end
    total++;
    if (bus.Busy !== 1'b0) begin bad++; $display("FAIL rd_busy_end got=%b exp=0", bus.Busy); end
  endtask

  task automatic test_alu;
    logic [7:0] exp_b [2];
    exp_b[0] = 8'hEF;
    exp_b[1] = 8'hBE;
    got.delete();
    early = 0;
    drive_alu(16'hBEEF);
    wait_idle("alu");
    total++;
    if (got.size() != 2) begin bad++; $display("FAIL alu_count got=%0d exp=2", got.size()); end
    for (int i = 0; i < 2 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_b[i]) begin bad++; $display("FAIL alu_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL alu_req_while_busy got=%0d exp=0", early); end
  endtask

  task automatic test_simul;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h34;
    exp_b[1] = 8'h12;
    exp_b[2] = 8'h77;
    got.delete();
    bus.ALU_OUT      = 16'h1234;
    bus.RdData       = 8'h77;
    bus.OUT_Valid    = 1'b1;
    bus.RdData_Valid = 1'b1;
    cyc(1);
    bus.OUT_Valid    = 1'b0;
    bus.RdData_Valid = 1'b0;
    wait_idle("simul");
    total++;
    if (got.size() != 3) begin bad++; $display("FAIL simul_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_b[i]) begin bad++; $display("FAIL simul_byte%0d got=%h exp=%h", i, got[i], exp_b[i]); end
    end
    total++;
    if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL simul_ovf got=%b exp=0", bus.Overflow); end
  endtask

  task automatic test_req_hold;
    int unstable = 0;
    got.delete();
    force_busy = 1'b1;
    drive_rd(8'h3C);
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== 8'h3C) unstable++;
      cyc(1);
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL hold_stable unstable_cycles=%0d exp=0", unstable); end
    force_busy = 1'b0;
    cyc(1);
    total++;
    if (bus.TX_D_VLD !== 1'b0) begin bad++; $display("FAIL hold_release_vld got=%b exp=0", bus.TX_D_VLD); end
    wait_idle("hold");
    total++;
    if (got.size() != 1 || got[0] !== 8'h3C) begin
      bad++; $display("FAIL hold_bytes count=%0d first=%h exp=1/3c", got.size(), got.size() ? got[0] : 8'h00);
    end
  endtask

  // Sender parks A0 in TX_P_DATA, so the FIFO holds 7 after four frames (1 free)
  task automatic test_overflow;
    logic [7:0] e;
    got.delete();
    force_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_alu({8'(8'hA1 + 2 * k), 8'(8'hA0 + 2 * k)});
      cyc(1);
    end
    total++;
    if (bus.Overflow !== 1'b0) begin bad++; $display("FAIL ovf_before got=%b exp=0", bus.Overflow); end
    drive_alu(16'hEEEE);
    total++;
    if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL ovf_alu_drop got=%b exp=1", bus.Overflow); end
    drive_rd(8'hA8);
    drive_rd(8'hEE);
    total++;
    if (bus.TX_D_VLD !== 1'b1 || bus.TX_P_DATA !== 8'hA0) begin
      bad++; $display("FAIL ovf_held vld=%b data=%h exp=1/a0", bus.TX_D_VLD, bus.TX_P_DATA);
    end
    force_busy = 1'b0;
    wait_idle("ovf");
    total++;
    if (got.size() != 9) begin bad++; $display("FAIL ovf_count got=%0d exp=9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      e = 8'(8'hA0 + i);
      total++;
      if (got[i] !== e) begin bad++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, got[i], e); end
    end
    total++;
    if (bus.Overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.Overflow); end
  endtask

  task automatic test_reset_mid;
    int vld_seen = 0;
    force_busy = 1'b1;
    drive_alu(16'h5150);
    cyc(1);
    drive_alu(16'h5352);
    total++;
    if (bus.TX_D_VLD !== 1'b1) begin bad++; $display("FAIL mid_pre_vld got=%b exp=1", bus.TX_D_VLD); end
    RST = 1'b0;
    #1;
    total++;
    if (bus.TX_D_VLD !== 1'b0 || bus.TX_P_DATA !== 8'h00) begin
      bad++; $display("FAIL mid_rst_out vld=%b data=%h exp=0/00", bus.TX_D_VLD, bus.TX_P_DATA);
    end
    total++;
    if (bus.Busy !== 1'b0 || bus.Overflow !== 1'b0) begin
      bad++; $display("FAIL mid_rst_status busy=%b ovf=%b exp=0/0", bus.Busy, bus.Overflow);
    end
    cyc(2);
    RST = 1'b1;
    force_busy = 1'b0;
    got.delete();
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (bus.TX_D_VLD !== 1'b0) vld_seen++;
    end
    total++;
    if (got.size() != 0 || vld_seen != 0) begin
      bad++; $display("FAIL mid_no_bytes sent=%0d vld_cycles=%0d exp=0/0", got.size(), vld_seen);
    end
    total++;
    if (bus.Busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.Busy); end
  endtask

  initial begin
    bus.ALU_OUT      = '0;
    bus.OUT_Valid    = 1'b0;
    bus.RdData       = '0;
    bus.RdData_Valid = 1'b0;
    test_reset();
    test_read();
    test_alu();
    test_simul();
    test_req_hold();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
